// File: rtl/hex_sseg_decoder_pkg.sv
// Shared seven-segment display definitions: glyph table, segment bit order,
// and the all-off pattern for active-low displays.
package hex_sseg_decoder_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_OFF_AL = 7'h7F;

    // Active-high lit segments {g,f,e,d,c,b,a}; b and d use lowercase glyphs
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/hex_glyph_rom.sv
// Combinational nibble-to-glyph lookup producing an active-high segment vector.
module hex_glyph_rom
    import hex_sseg_decoder_pkg::*;
(
    input  logic [3:0] x,
    output logic [6:0] lit
);

    // Table lookup; every nibble value is a legal glyph
    always_comb begin
        lit = GLYPH_TABLE[x];
    end

endmodule

// File: rtl/hex_sseg_decoder.sv
// Registered hex-to-seven-segment decoder with blanking, selectable polarity,
// capture enable and asynchronous reset to the all-segments-off pattern.
module hex_sseg_decoder
    import hex_sseg_decoder_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       blank,
    input  logic [3:0] x,
    output logic [6:0] r
);

    localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? SEG_OFF_AL : 7'h00;

    logic [6:0] lit_s;
    logic [6:0] masked_s;
    logic [6:0] pattern_s;
    logic [6:0] seg_r;

    hex_glyph_rom u_glyph_rom (
        .x   (x),
        .lit (lit_s)
    );

    // Blank forces every segment dark before polarity is applied
    always_comb begin
        masked_s = 7'h00;
        if (blank) begin
            masked_s = 7'h00;
        end else begin
            masked_s = lit_s;
        end
    end

    // Polarity adjustment toward the display's drive sense
    always_comb begin
        pattern_s = 7'h00;
        if (ACTIVE_LOW) begin
            pattern_s = ~masked_s;
        end else begin
            pattern_s = masked_s;
        end
    end

    // Output register: reset clears to dark at once, en captures the pattern
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_r <= SEG_OFF;
        end else if (en) begin
            seg_r <= pattern_s;
        end else begin
            seg_r <= seg_r;
        end
    end

    assign r = seg_r;

endmodule

// File: tb/tb_hex_sseg_decoder.sv
// Directed bench for hex_sseg_decoder: both polarities driven from shared inputs.
module tb_hex_sseg_decoder;

    logic       clk;
    logic       reset;
    logic       en;
    logic       blank;
    logic [3:0] x;
    logic [6:0] r_al;
    logic [6:0] r_ah;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [3:0] x;
        logic       blank;
        logic [6:0] exp_al;
        logic [6:0] exp_ah;
    } vec_t;

    vec_t vecs [18];

    hex_sseg_decoder #(.ACTIVE_LOW(1'b1)) dut_al (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .blank (blank),
        .x     (x),
        .r     (r_al)
    );

    hex_sseg_decoder #(.ACTIVE_LOW(1'b0)) dut_ah (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .blank (blank),
        .x     (x),
        .r     (r_ah)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] al_tab [16];
        logic [6:0] ah_tab [16];
        al_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        ah_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{x: 4'(i), blank: 1'b0, exp_al: al_tab[i], exp_ah: ah_tab[i]};
        end
        vecs[16] = '{x: 4'h8, blank: 1'b1, exp_al: 7'h7F, exp_ah: 7'h00};
        vecs[17] = '{x: 4'hF, blank: 1'b1, exp_al: 7'h7F, exp_ah: 7'h00};

        tests_run    = 0;
        tests_failed = 0;
        clk   = 1'b0;
        reset = 1'b0;
        en    = 1'b0;
        blank = 1'b0;
        x     = 4'h0;

        // Async reset before any clock edge
        #2 reset = 1'b1;
        #1;
        check("reset_async_al", r_al, 7'h7F);
        check("reset_async_ah", r_ah, 7'h00);
        #1 reset = 1'b0;
        x = 4'h3;
        tick();
        tick();
        check("reset_hold_en0", r_al, 7'h7F);

        // Full sweep plus blanked entries
        en = 1'b1;
        for (int i = 0; i < 18; i++) begin
            x     = vecs[i].x;
            blank = vecs[i].blank;
            tick();
            check($sformatf("sweep_al[%0d]", i), r_al, vecs[i].exp_al);
            check($sformatf("sweep_ah[%0d]", i), r_ah, vecs[i].exp_ah);
        end
        blank = 1'b0;

        // Hold with en low
        x = 4'h2;
        tick();
        check("hold_load", r_al, 7'h24);
        en = 1'b0;
        x  = 4'h7;
        tick();
        check("hold_1", r_al, 7'h24);
        tick();
        check("hold_2", r_al, 7'h24);
        en = 1'b1;
        tick();
        check("hold_release", r_al, 7'h78);

        // Blank then unblank
        x     = 4'h8;
        blank = 1'b1;
        tick();
        check("blank_on", r_al, 7'h7F);
        blank = 1'b0;
        tick();
        check("blank_off_al", r_al, 7'h00);
        check("blank_off_ah", r_ah, 7'h7F);
        en    = 1'b0;
        blank = 1'b1;
        tick();
        check("blank_ignored_en0", r_al, 7'h00);
        blank = 1'b0;
        en    = 1'b1;

        // Mid-stream reset between edges
        x = 4'h4;
        tick();
        check("mid_load", r_al, 7'h19);
        #2 reset = 1'b1;
        #1;
        check("mid_reset_al", r_al, 7'h7F);
        check("mid_reset_ah", r_ah, 7'h00);
        reset = 1'b0;
        tick();
        check("mid_recover", r_al, 7'h19);

        // Reset held across an edge wins over en
        x     = 4'h1;
        reset = 1'b1;
        tick();
        check("reset_priority", r_al, 7'h7F);
        reset = 1'b0;
        tick();
        check("after_priority_al", r_al, 7'h79);
        check("after_priority_ah", r_ah, 7'h06);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
